// File: rtl/memref_multiport.sv
// Shared-array memory model with NUM_PORTS independent read/write ports, a RD_LATENCY
// read pipeline, sticky collision/out-of-range flags and saturating per-port access counters.
module memref_multiport #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 64,
   parameter int ADDR_W     = 6,
   parameter int NUM_PORTS  = 2,
   parameter int RD_LATENCY = 1,
   parameter int CNT_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS*ADDR_W-1:0] addr,
   input  logic [NUM_PORTS-1:0]        rd_en,
   input  logic [NUM_PORTS-1:0]        wr_en,
   input  logic [NUM_PORTS*WIDTH-1:0]  wr_data,
   output logic [NUM_PORTS*WIDTH-1:0]  rd_data,
   output logic [NUM_PORTS-1:0]        rd_valid,
   output logic                        wr_collision,
   output logic                        oob_err,
   output logic [NUM_PORTS*CNT_W-1:0]  rd_count,
   output logic [NUM_PORTS*CNT_W-1:0]  wr_count
);

   if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_chk_addr_w
      $error("memref_multiport: 2**ADDR_W must be >= DEPTH");
   end
   if (NUM_PORTS < 1 || NUM_PORTS > 4) begin : g_chk_ports
      $error("memref_multiport: NUM_PORTS must be in 1..4");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_chk_latency
      $error("memref_multiport: RD_LATENCY must be in 1..4");
   end
   if (DEPTH < 1 || WIDTH < 1 || CNT_W < 1) begin : g_chk_sizes
      $error("memref_multiport: DEPTH, WIDTH and CNT_W must be positive");
   end

   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [ADDR_W-1:0]    ap [NUM_PORTS];
   logic [NUM_PORTS-1:0] inr;
   logic [WIDTH-1:0]     rdat_d [NUM_PORTS];
   logic                 col_d, oob_d;
   logic                 col_q, oob_q;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_decode
      assign ap[p]     = addr[p*ADDR_W +: ADDR_W];
      assign inr[p]    = ({1'b0, ap[p]} < DEPTH_C);
      // Out-of-range reads return zero rather than touching the array.
      assign rdat_d[p] = inr[p] ? mem_q[ap[p]] : '0;
   end

   always_comb begin
      col_d = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int j = i + 1; j < NUM_PORTS; j++) begin
            if (wr_en[i] && wr_en[j] && (ap[i] == ap[j])) col_d = 1'b1;
         end
      end
   end

   assign oob_d = |((rd_en | wr_en) & ~inr);

   // Highest port is written first so the lowest-indexed writer lands last and wins.
   always_ff @(posedge clk) begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
         if (wr_en[p] && inr[p]) mem_q[ap[p]] <= wr_data[p*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q <= 1'b0;
         oob_q <= 1'b0;
      end else begin
         col_q <= col_q | col_d;
         oob_q <= oob_q | oob_d;
      end
   end

   assign wr_collision = col_q;
   assign oob_err      = oob_q;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [RD_LATENCY-1:0] vld_q;
      logic [WIDTH-1:0]      dat_q [RD_LATENCY];
      logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
      logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;

      // Stage 0 captures the pre-edge array word; each stage only loads when its
      // incoming valid is set, so the final stage holds between strobes.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            vld_q <= '0;
            for (int s = 0; s < RD_LATENCY; s++) dat_q[s] <= '0;
         end else begin
            vld_q[0] <= rd_en[p];
            if (rd_en[p]) dat_q[0] <= rdat_d[p];
            for (int s = 1; s < RD_LATENCY; s++) begin
               vld_q[s] <= vld_q[s-1];
               if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
            end
         end
      end

      assign rd_valid[p]                = vld_q[RD_LATENCY-1];
      assign rd_data[p*WIDTH +: WIDTH]  = dat_q[RD_LATENCY-1];

      assign rd_cnt_d = (rd_en[p] && !(&rd_cnt_q)) ? rd_cnt_q + CNT_W'(1) : rd_cnt_q;
      assign wr_cnt_d = (wr_en[p] && !(&wr_cnt_q)) ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
         end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
         end
      end

      assign rd_count[p*CNT_W +: CNT_W] = rd_cnt_q;
      assign wr_count[p*CNT_W +: CNT_W] = wr_cnt_q;
   end

endmodule

// File: tb/tb_memref_multiport.sv
// Directed bench for memref_multiport: three instances (default, latency-3/depth-48/4-bit
// counters, latency-2) share one stimulus stream and are checked against hand-derived values.
module tb_memref_multiport;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [11:0] addr;
   logic [1:0]  rd_en, wr_en;
   logic [63:0] wr_data;

   logic [63:0] a_rdata, b_rdata, c_rdata;
   logic [1:0]  a_vld, b_vld, c_vld;
   logic        a_col, b_col, c_col, a_oob, b_oob, c_oob;
   logic [31:0] a_rdc, a_wrc, c_rdc, c_wrc;
   logic [7:0]  b_rdc, b_wrc;

   logic [31:0] mem_exp [64];
   int n_vec  = 0;
   int n_miss = 0;

   memref_multiport u_dut_a (
      .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data),
      .rd_data(a_rdata), .rd_valid(a_vld), .wr_collision(a_col), .oob_err(a_oob),
      .rd_count(a_rdc), .wr_count(a_wrc)
   );

   memref_multiport #(.DEPTH(48), .RD_LATENCY(3), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data),
      .rd_data(b_rdata), .rd_valid(b_vld), .wr_collision(b_col), .oob_err(b_oob),
      .rd_count(b_rdc), .wr_count(b_wrc)
   );

   memref_multiport #(.RD_LATENCY(2)) u_dut_c (
      .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data),
      .rd_data(c_rdata), .rd_valid(c_vld), .wr_collision(c_col), .oob_err(c_oob),
      .rd_count(c_rdc), .wr_count(c_wrc)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [1:0] re, input logic [1:0] we, input logic [5:0] a0,
                        input logic [5:0] a1, input logic [31:0] d0, input logic [31:0] d1);
      rd_en   = re;
      wr_en   = we;
      addr    = {a1, a0};
      wr_data = {d1, d0};
   endtask

   task automatic idle();
      drive(2'b00, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      for (int i = 0; i < 64; i++) mem_exp[i] = 32'(i + 1);
      tick();
      tick();

      // reset state
      chk("rst_vld", 64'({a_vld, b_vld, c_vld}), 64'd0);
      chk("rst_rdata", a_rdata | b_rdata | c_rdata, 64'd0);
      chk("rst_flags", 64'({a_col, a_oob, b_col, b_oob, c_col, c_oob}), 64'd0);
      chk("rst_cnt", 64'({a_rdc, a_wrc}), 64'd0);
      rst = 1'b1;

      // preload mem[i] = i+1 through port 0
      for (int i = 0; i < 64; i++) begin
         drive(2'b00, 2'b01, 6'(i), 6'd0, 32'(i + 1), 32'd0);
         tick();
      end
      idle();
      chk("pre_wrcA", 64'(a_wrc[15:0]), 64'd64);
      chk("pre_wrcB_sat", 64'(b_wrc[3:0]), 64'd15);
      chk("pre_oobB", 64'(b_oob), 64'd1);
      chk("pre_oobA", 64'(a_oob), 64'd0);
      do_reset();
      chk("async_rst_wrc", 64'(a_wrc), 64'd0);
      chk("async_rst_oobB", 64'(b_oob), 64'd0);

      // single read, latency 1/2/3
      drive(2'b01, 2'b00, 6'd5, 6'd0, 32'd0, 32'd0);
      chk("t1_vld_c10", 64'(a_vld[0]), 64'd0);
      tick();
      idle();
      chk("t1_vld_c11", 64'(a_vld[0]), 64'd1);
      chk("t1_data", 64'(a_rdata[31:0]), 64'd6);
      chk("t1_c_early", 64'(c_vld[0]), 64'd0);
      tick();
      chk("t1_vld_c12", 64'(a_vld[0]), 64'd0);
      chk("t1_hold", 64'(a_rdata[31:0]), 64'd6);
      chk("t1_c_vld", 64'(c_vld[0]), 64'd1);
      chk("t1_c_data", 64'(c_rdata[31:0]), 64'd6);
      tick();
      chk("t1_b_vld", 64'(b_vld[0]), 64'd1);
      chk("t1_b_data", 64'(b_rdata[31:0]), 64'd6);
      chk("t1_c_done", 64'(c_vld[0]), 64'd0);

      // back-to-back reads on port 1, latency 3
      drive(2'b10, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0);
      tick();
      drive(2'b10, 2'b00, 6'd0, 6'd1, 32'd0, 32'd0);
      tick();
      chk("t2_b_early", 64'(b_vld[1]), 64'd0);
      drive(2'b10, 2'b00, 6'd0, 6'd2, 32'd0, 32'd0);
      tick();
      idle();
      for (int k = 0; k < 3; k++) begin
         chk("t2_b_vld", 64'(b_vld[1]), 64'd1);
         chk("t2_b_data", 64'(b_rdata[63:32]), 64'(k + 1));
         tick();
      end
      chk("t2_b_vld_end", 64'(b_vld[1]), 64'd0);
      chk("t2_b_rdc", 64'(b_rdc[7:4]), 64'd3);

      // read during write, cross-port and same-port
      drive(2'b10, 2'b01, 6'd7, 6'd7, 32'h0000_00AA, 32'd0);
      tick();
      mem_exp[7] = 32'h0000_00AA;
      drive(2'b10, 2'b00, 6'd0, 6'd7, 32'd0, 32'd0);
      chk("t3_old", 64'(a_rdata[63:32]), 64'd8);
      tick();
      idle();
      chk("t3_new", 64'(a_rdata[63:32]), 64'h0000_00AA);
      drive(2'b01, 2'b01, 6'd3, 6'd0, 32'h0000_0033, 32'd0);
      tick();
      mem_exp[3] = 32'h0000_0033;
      drive(2'b01, 2'b00, 6'd3, 6'd0, 32'd0, 32'd0);
      chk("t3_same_old", 64'(a_rdata[31:0]), 64'd4);
      tick();
      idle();
      chk("t3_same_new", 64'(a_rdata[31:0]), 64'h0000_0033);

      // write collision on address 9
      do_reset();
      drive(2'b00, 2'b11, 6'd9, 6'd9, 32'h0000_0011, 32'h0000_0022);
      chk("t4_col_before", 64'(a_col), 64'd0);
      tick();
      mem_exp[9] = 32'h0000_0011;
      drive(2'b01, 2'b00, 6'd9, 6'd0, 32'd0, 32'd0);
      chk("t4_col", 64'(a_col), 64'd1);
      chk("t4_wrc", 64'(a_wrc), 64'h0001_0001);
      tick();
      idle();
      chk("t4_winner", 64'(a_rdata[31:0]), 64'h0000_0011);
      tick();
      tick();
      chk("t4_col_sticky", 64'(a_col), 64'd1);
      chk("t4_col_c", 64'(c_col), 64'd1);
      chk("t4_b_data", 64'(b_rdata[31:0]), 64'h0000_0011);

      // out-of-range on the depth-48 instance
      chk("t5_oob_before", 64'(b_oob), 64'd0);
      drive(2'b01, 2'b00, 6'd50, 6'd0, 32'd0, 32'd0);
      tick();
      idle();
      chk("t5_oob", 64'(b_oob), 64'd1);
      chk("t5_oobA", 64'(a_oob), 64'd0);
      chk("t5_a_data", 64'(a_rdata[31:0]), 64'd51);
      tick();
      tick();
      chk("t5_b_vld", 64'(b_vld[0]), 64'd1);
      chk("t5_b_zero", 64'(b_rdata[31:0]), 64'd0);
      drive(2'b00, 2'b10, 6'd0, 6'd50, 32'd0, 32'h0000_DEAD);
      tick();
      idle();
      mem_exp[50] = 32'h0000_DEAD;

      // reset with a read in flight in the latency-2 instance
      drive(2'b01, 2'b00, 6'd1, 6'd0, 32'd0, 32'd0);
      tick();
      idle();
      #2;
      rst = 1'b0;
      #1;
      chk("t6_vld", 64'(c_vld[0]), 64'd0);
      chk("t6_rdc", 64'(c_rdc), 64'd0);
      chk("t6_flags", 64'({c_col, b_oob}), 64'd0);
      chk("t6_rdata", c_rdata, 64'd0);
      tick();
      rst = 1'b1;
      chk("t6_vld_held", 64'(c_vld[0]), 64'd0);
      tick();
      chk("t6_vld_after", 64'(c_vld[0]), 64'd0);

      // full sweep on port 0: array contents after all of the above
      for (int i = 0; i < 66; i++) begin
         if (i < 64) drive(2'b01, 2'b00, 6'(i), 6'd0, 32'd0, 32'd0);
         else idle();
         tick();
         if (i < 64) chk("swpA", 64'(a_rdata[31:0]), 64'(mem_exp[i]));
         if (i >= 1 && i <= 64) chk("swpC", 64'(c_rdata[31:0]), 64'(mem_exp[i-1]));
         if (i >= 2) chk("swpB", 64'(b_rdata[31:0]), (i - 2 < 48) ? 64'(mem_exp[i-2]) : 64'd0);
      end
      chk("swp_rdcA", 64'(a_rdc[15:0]), 64'd64);
      chk("swp_rdcC", 64'(c_rdc[15:0]), 64'd64);
      chk("swp_rdcB_sat", 64'(b_rdc[3:0]), 64'd15);
      chk("swp_oobB", 64'(b_oob), 64'd1);

      // 20 reads on port 1: 4-bit counter saturates at 15
      for (int i = 0; i < 20; i++) begin
         drive(2'b10, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0);
         tick();
      end
      idle();
      chk("sat_rdcB", 64'(b_rdc[7:4]), 64'd15);
      chk("sat_rdcA", 64'(a_rdc[31:16]), 64'd20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/memref_multiport.md
Name: memref_multiport

Overview:
- Parametrised memory model used by the kernel testbenches (HIR vs HLS comparison).
- Provides NUM_PORTS independent read/write ports onto one shared array, with configurable read latency.
- Resolves same-cycle write collisions deterministically and flags them.
- Keeps per-port access counters so benches can compare memory traffic between generated designs.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 64, number of words; need not be a power of two.
- ADDR_W, 6, address width; must satisfy 2**ADDR_W >= DEPTH.
- NUM_PORTS, 2, number of ports; legal range 1..4.
- RD_LATENCY, 1, cycles from rd_en to rd_valid/rd_data; legal range 1..4.
- CNT_W, 16, width of each access counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  NUM_PORTS*ADDR_W  packed per-port address; port p occupies bits [p*ADDR_W +: ADDR_W].
- rd_en  in  NUM_PORTS  per-port read request.
- wr_en  in  NUM_PORTS  per-port write request.
- wr_data  in  NUM_PORTS*WIDTH  packed per-port write data.
- rd_data  out  NUM_PORTS*WIDTH  packed per-port read data.
- rd_valid  out  NUM_PORTS  per-port read-data-valid strobe.
- wr_collision  out  1  sticky flag: two or more ports wrote the same address in one cycle.
- oob_err  out  1  sticky flag: an access used an address >= DEPTH.
- rd_count  out  NUM_PORTS*CNT_W  per-port accepted-read counter.
- wr_count  out  NUM_PORTS*CNT_W  per-port accepted-write counter.

Behaviour:
- Reset (rst=0, asynchronous):
  - rd_data=0, rd_valid=0, wr_collision=0, oob_err=0, all counters=0.
  - Read pipeline is flushed; reads in flight when reset asserts are discarded and never produce rd_valid.
  - Array contents are not cleared; benches preload them hierarchically.
- Read:
  - rd_en[p] at edge k samples the array at edge k (read-first).
  - Data passes through an RD_LATENCY-stage pipeline.
  - rd_valid[p]=1 and rd_data[p] are presented for exactly one cycle, RD_LATENCY cycles after the request.
  - Between valid strobes rd_data[p] holds its last value.
  - Back-to-back reads on a port are fully pipelined at one per cycle.
- Write: wr_en[p] updates the array at the edge it is sampled.
- Read during write, same address, same cycle: the reader returns the old value, whether the write comes from the same port or another port. It returns the new value from the following cycle.
- rd_en[p] and wr_en[p] together on one port: both are performed; the read returns the old value.
- Write collision (same address, two or more ports, same cycle):
  - The lowest-indexed port wins; the other writes are dropped.
  - wr_collision is set and stays set until reset.
  - Every participating port still increments its wr_count.
- Out-of-range address (addr >= DEPTH):
  - Write is dropped.
  - Read completes with the normal latency and returns 0.
  - oob_err is set (sticky).
  - The counter still increments.
- Counters:
  - rd_count[p] increments on each sampled rd_en[p]; wr_count[p] on each sampled wr_en[p].
  - Counters saturate at 2**CNT_W-1 and do not wrap.
- Behaviour is the same for every RD_LATENCY value; the valid shift register has depth RD_LATENCY.
- Illegal parameters (e.g. 2**ADDR_W < DEPTH, NUM_PORTS > 4) cause an elaboration-time $error.

Test Plan:
- Default params, preload mem[i]=i+1; port0 reads addr 5 at cycle 10 -> rd_valid[0]=1 at cycle 11 with rd_data[0]=6; rd_valid low at cycles 10 and 12.
- RD_LATENCY=3; port1 reads addrs 0,1,2 back-to-back -> rd_valid[1] high for 3 consecutive cycles starting 3 cycles after the first request, data 1,2,3; rd_count[1]=3.
- Port0 writes 0xAA to addr 7 while port1 reads addr 7 in the same cycle -> port1 returns the old value 8; port1 re-reads addr 7 the next cycle -> 0xAA.
- Port0 writes 0x11 and port1 writes 0x22 to addr 9 in the same cycle -> mem[9]=0x11; wr_collision=1 and stays 1; wr_count = 1 on both ports.
- DEPTH=48, ADDR_W=6; read addr 50 -> returns 0 after latency, oob_err=1; write addr 50 -> no array word changes.
- Assert rst=0 mid-read with RD_LATENCY=2 and one request in flight -> rd_valid stays 0, counters and flags clear immediately (asynchronously), mem[0..63] unchanged; CNT_W=4, issue 20 reads -> rd_count saturates at 15.
